// File: rtl/float_pkg.sv
// Shared types and constants for the float-to-posit conversion path.
// Posit constants are returned 64 bits wide; callers size-cast them to N bits.
package float_pkg;

  typedef enum logic [1:0] {ZERO, NAR, TINY, NORM} fclass_t;

  function automatic int exp_bias(input int exp_size);
    return (1 << (exp_size - 1)) - 1;
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/posit_assembler.sv
// Builds the unsigned posit body (regime, exponent, fraction) and rounds it to
// nearest-even, saturating to maxpos/minpos instead of overflowing or underflowing.
module posit_assembler
  import float_pkg::*;
#(
  parameter int N         = 16,
  parameter int ES        = 1,
  parameter int MANT_SIZE = 52,
  parameter int KW        = 12
) (
  input  logic signed [KW-1:0]        k_i,
  input  logic        [ES-1:0]        ef_i,
  input  logic        [MANT_SIZE-1:0] frac_i,
  input  logic                        sat_max_i,
  input  logic                        sat_min_i,
  output logic        [N-2:0]         body_o
);

  // Longest regime is N bits (k = N-2), so the stream never drops tail bits.
  localparam int W = N + ES + MANT_SIZE;
  localparam logic [N-1:0] MAXPOS = N'(posit_maxpos(N));
  localparam logic [N-1:0] MINPOS = N'(posit_minpos(N));

  logic [KW-1:0]  kmag;
  logic [KW-1:0]  rlen;
  logic [W-1:0]   regime;
  logic [W-1:0]   tail;
  logic [W-1:0]   stream;
  logic [N-2:0]   trunc;
  logic           guard;
  logic           sticky;
  logic           round_up;
  logic [N-1:0]   rnd;

  always_comb begin
    kmag = k_i[KW-1] ? $unsigned(-k_i) : $unsigned(k_i);
    if (!k_i[KW-1]) begin
      regime = ~({W{1'b1}} >> (kmag + KW'(1)));
      rlen   = kmag + KW'(2);
    end else begin
      regime = {1'b1, {(W-1){1'b0}}} >> kmag;
      rlen   = kmag + KW'(1);
    end
    tail     = {ef_i, frac_i, {N{1'b0}}} >> rlen;
    stream   = regime | tail;
    trunc    = stream[W-1 -: N-1];
    guard    = stream[W-N];
    sticky   = |stream[W-N-1:0];
    round_up = guard & (sticky | trunc[0]);
    rnd      = {1'b0, trunc} + N'(round_up);

    if (sat_max_i || rnd[N-1]) begin
      body_o = MAXPOS[N-2:0];
    end else if (sat_min_i) begin
      body_o = MINPOS[N-2:0];
    end else begin
      body_o = rnd[N-2:0];
    end
  end

endmodule

// File: rtl/float_to_posit_pipe.sv
// Three-stage float-field to posit converter with valid/ready on both sides.
// A single enable freezes every stage, bubbles included, whenever the output stalls.
module float_to_posit_pipe
  import float_pkg::*;
#(
  parameter int N         = 16,
  parameter int ES        = 1,
  parameter int FSIZE     = 64,
  parameter int EXP_SIZE  = 11,
  parameter int MANT_SIZE = 52
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_i,
  input  logic [EXP_SIZE-1:0]  exp_i,
  input  logic [MANT_SIZE-1:0] frac_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         posit_o
);

  localparam int KW = EXP_SIZE + 1;
  localparam logic signed [KW-1:0] BIAS_K = KW'(exp_bias(EXP_SIZE));
  localparam logic signed [KW-1:0] K_LIM  = KW'(N - 2);
  localparam logic [N-1:0]         NAR_P  = N'(posit_nar(N));

  if (FSIZE != 1 + EXP_SIZE + MANT_SIZE) begin : g_bad_fsize
    $error("FSIZE does not match sign + exponent + fraction widths");
  end

  logic en;

  logic                  v1_q, sign1_q;
  fclass_t               cls1_q, cls1_d;
  logic [EXP_SIZE-1:0]   exp1_q;
  logic [MANT_SIZE-1:0]  frac1_q;

  logic                  v2_q, sign2_q, smax2_q, smin2_q;
  fclass_t               cls2_q;
  logic signed [KW-1:0]  k2_q;
  logic [ES-1:0]         ef2_q;
  logic [MANT_SIZE-1:0]  frac2_q;

  logic signed [KW-1:0]  e_s, k_s;
  logic                  smax_d, smin_d;

  logic                  out_valid_q;
  logic [N-1:0]          posit_q, posit_d;
  logic [N-2:0]          body;
  logic [N-1:0]          mag;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign posit_o   = posit_q;

  always_comb begin
    if (&exp_i)          cls1_d = NAR;
    else if (exp_i != '0) cls1_d = NORM;
    else if (frac_i != '0) cls1_d = TINY;
    else                 cls1_d = ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      cls1_q  <= ZERO;
      exp1_q  <= '0;
      frac1_q <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      sign1_q <= sign_i;
      cls1_q  <= cls1_d;
      exp1_q  <= exp_i;
      frac1_q <= frac_i;
    end
  end

  always_comb begin
    e_s    = $signed({1'b0, exp1_q}) - BIAS_K;
    k_s    = e_s >>> ES;
    smax_d = k_s > K_LIM;
    smin_d = (k_s < -K_LIM) || (cls1_q == TINY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      cls2_q  <= ZERO;
      k2_q    <= '0;
      ef2_q   <= '0;
      frac2_q <= '0;
      smax2_q <= 1'b0;
      smin2_q <= 1'b0;
    end else if (en) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      cls2_q  <= cls1_q;
      k2_q    <= k_s;
      ef2_q   <= e_s[ES-1:0];
      frac2_q <= frac1_q;
      smax2_q <= smax_d;
      smin2_q <= smin_d;
    end
  end

  posit_assembler #(
    .N(N), .ES(ES), .MANT_SIZE(MANT_SIZE), .KW(KW)
  ) u_asm (
    .k_i       (k2_q),
    .ef_i      (ef2_q),
    .frac_i    (frac2_q),
    .sat_max_i (smax2_q),
    .sat_min_i (smin2_q),
    .body_o    (body)
  );

  // Zero and NaR carry no sign; everything else is negated in two's complement.
  always_comb begin
    mag = {1'b0, body};
    case (cls2_q)
      ZERO:    posit_d = '0;
      NAR:     posit_d = NAR_P;
      default: posit_d = sign2_q ? (~mag + N'(1)) : mag;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      posit_q     <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      posit_q     <= posit_d;
    end
  end

endmodule

// File: tb/tb_float_to_posit_pipe.sv
// Scoreboard bench for float_to_posit_pipe: float64 vectors with hand-derived posit16 results.
module tb_float_to_posit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sign_i;
  logic [10:0] exp_i;
  logic [51:0] frac_i;
  logic        out_valid, out_ready;
  logic [15:0] posit_o;

  always #5 clk = ~clk;

  float_to_posit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_i    (sign_i),
    .exp_i     (exp_i),
    .frac_i    (frac_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .posit_o   (posit_o)
  );

  typedef struct {
    logic [63:0] f;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    int          cyc;
  } sb_t;

  localparam int NV = 22;
  vec_t        vecs[NV];
  sb_t         sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          popped = 0;
  bit          lat_chk = 1'b1;
  logic [15:0] cur_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none", posit_o);
          end else if (out_ready) begin
            e = sb_q.pop_front();
            popped++;
            chk("posit", {16'h0, posit_o}, {16'h0, e.p});
            if (lat_chk) chk("latency", cyc - e.cyc, 3);
          end else begin
            chk("stall_hold", {16'h0, posit_o}, {16'h0, sb_q[0].p});
            chk("stall_in_ready", {31'h0, in_ready}, 0);
          end
        end
        if (in_valid && in_ready) sb_q.push_back('{cur_exp, cyc});
      end
    end
  endtask

  task automatic send(input logic [63:0] f, input logic [15:0] p);
    bit ok = 1'b0;
    sign_i   = f[63];
    exp_i    = f[62:52];
    frac_i   = f[51:0];
    cur_exp  = p;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int base;
    vecs[0]  = '{64'h3FF0000000000000, 16'h4000};  // 1.0
    vecs[1]  = '{64'hBFF0000000000000, 16'hC000};  // -1.0
    vecs[2]  = '{64'h405EE00000000000, 16'h79DC};  // 123.5
    vecs[3]  = '{64'hC05EE00000000000, 16'h8624};  // -123.5
    vecs[4]  = '{64'h0000000000000000, 16'h0000};  // +0
    vecs[5]  = '{64'h8000000000000000, 16'h0000};  // -0
    vecs[6]  = '{64'h7FF0000000000000, 16'h8000};  // +Inf
    vecs[7]  = '{64'hFFF0000000000000, 16'h8000};  // -Inf
    vecs[8]  = '{64'h7FF8000000000000, 16'h8000};  // NaN
    vecs[9]  = '{64'h7E37E43C8800759C, 16'h7FFF};  // 1e300
    vecs[10] = '{64'h0170000000000000, 16'h0001};  // 2^-1000
    vecs[11] = '{64'h8170000000000000, 16'hFFFF};  // -2^-1000
    vecs[12] = '{64'h0000000000000001, 16'h0001};  // subnormal
    vecs[13] = '{64'h3FF0008000000000, 16'h4000};  // tie, lsb 0
    vecs[14] = '{64'h3FF0008000000001, 16'h4001};  // above tie
    vecs[15] = '{64'h3FF0018000000000, 16'h4002};  // tie, lsb 1
    vecs[16] = '{64'h4000000000000000, 16'h5000};  // 2.0
    vecs[17] = '{64'h3FE0000000000000, 16'h3000};  // 0.5
    vecs[18] = '{64'hBFE0000000000000, 16'hD000};  // -0.5
    vecs[19] = '{64'h41B0000000000000, 16'h7FFF};  // 2^28, k = N-2
    vecs[20] = '{64'h3E30000000000000, 16'h0001};  // 2^-28, k = -(N-2)
    vecs[21] = '{64'h3E20000000000000, 16'h0001};  // 2^-29, below minpos

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign_i = 1'b0; exp_i = '0; frac_i = '0; cur_exp = '0;
    fork monitor(); join_none
    #1;
    chk("reset_out_valid", {31'h0, out_valid}, 0);
    chk("reset_posit", {16'h0, posit_o}, 0);
    chk("reset_in_ready", {31'h0, in_ready}, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_in_ready", {31'h0, in_ready}, 1);

    // Single isolated conversion, then the whole table back-to-back.
    send(vecs[0].f, vecs[0].p);
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < NV; i++) send(vecs[i].f, vecs[i].p);
    in_valid = 1'b0;
    drain();

    // Eight-deep stream with the output stalled for four cycles.
    lat_chk = 1'b0;
    base = popped;
    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i + 2].f, vecs[i + 2].p);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", popped - base, 8);
    lat_chk = 1'b1;

    // Reset while the pipe is full and stalled.
    out_ready = 1'b0;
    send(vecs[0].f, vecs[0].p);
    send(vecs[16].f, vecs[16].p);
    send(vecs[1].f, vecs[1].p);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_out_valid", {31'h0, out_valid}, 1);
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", {31'h0, out_valid}, 0);
    chk("mid_reset_posit", {16'h0, posit_o}, 0);
    chk("mid_reset_in_ready", {31'h0, in_ready}, 1);
    sb_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_out_valid", {31'h0, out_valid}, 0);
    send(vecs[2].f, vecs[2].p);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
